spi_shadow_register: RTL and testbench
======================================

SPI_SHADOW_REGISTER -- requirements
Module: spi_shadow_register

Interface
REQ-001 Parameter WIDTH, default 180: number of register bits; SHALL be 8..1024.
REQ-002 Parameter RESET_VAL, default all-zero WIDTH bits: value of spi_bits after reset.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth on spi_cs_b, spi_sclk and spi_sdi; SHALL be 2..4.
REQ-004 Parameter CPOL, default 0: idle level of spi_sclk.
REQ-005 Parameter CPHA, default 0: 0 = sample on leading SCLK edge and launch on trailing edge; 1 = launch on leading edge and sample on trailing edge.
REQ-006 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-007 rst_b  input  1  reset, asynchronous, active-low.
REQ-008 spi_cs_b  input  1  chip select, active low, asynchronous to clk.
REQ-009 spi_sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-010 spi_sdi  input  1  serial data in (MOSI), MSB first.
REQ-011 spi_sdo  output  1  serial data out (MISO), MSB first, registered.
REQ-012 spi_bits  output  WIDTH  committed shadow register, parallel output; changes only at commit or reset.
REQ-013 load_pulse  output  1  one-clk pulse when a valid frame is committed.
REQ-014 frame_err  output  1  one-clk pulse when a frame ends with a bad bit count.

Function
REQ-015 Each SPI input SHALL pass through SYNC_STAGES flops; one further flop SHALL hold the previous synced cs and sclk values for edge detection.
REQ-016 Leading edge SHALL be the synced-sclk transition away from CPOL; trailing edge SHALL be the return to CPOL.
REQ-017 The block SHALL keep a WIDTH-bit shift register separate from spi_bits, plus a bit counter of width clog2(WIDTH+2).
REQ-018 On synced cs falling (select), the shift register SHALL load spi_bits (readback), the counter SHALL clear, and spi_sdo SHALL take spi_bits[WIDTH-1] on the same cycle.
REQ-019 On a sample edge while selected, the shift register SHALL shift left with synced sdi entering bit 0, and the counter SHALL increment, saturating at WIDTH+1.
REQ-020 On a launch edge while selected, spi_sdo SHALL take shift[WIDTH-1]; with CPHA=1, the first leading edge SHALL re-present the MSB without losing it.
REQ-021 On synced cs rising (deselect) with counter == WIDTH, spi_bits SHALL take the shift register and load_pulse SHALL be 1 for exactly the next cycle.
REQ-022 On deselect with counter != WIDTH and counter != 0, spi_bits SHALL be unchanged and frame_err SHALL pulse for one cycle.
REQ-023 On deselect with counter == 0, there SHALL be no commit and no error.
REQ-024 On deselect, the counter SHALL clear.
REQ-025 While deselected, spi_sdo SHALL be 1 and sclk edges SHALL be ignored.
REQ-026 If a deselect and an sclk edge are detected in the same clk cycle, the deselect SHALL take priority and the edge SHALL be dropped.
REQ-027 If select and deselect fall in consecutive cycles (a glitch), the block SHALL treat it as a counter==0 frame with no side effects.
REQ-028 End-to-end latency SHALL be SYNC_STAGES+1 clk cycles from an SPI pin edge to its effect; spi_bits SHALL update SYNC_STAGES+2 cycles after the cs_b pin rises.
REQ-029 The operating constraint SHALL be SCLK high and low phases, and CS setup/hold to SCLK, each at least SYNC_STAGES+2 clk periods.
REQ-030 load_pulse and frame_err SHALL never be 1 in the same cycle.

Reset
REQ-031 While rst_b is low: spi_bits = RESET_VAL, shift register = 0, counter = 0, spi_sdo = 1, load_pulse = 0, frame_err = 0.
REQ-032 While rst_b is low, the cs synchroniser SHALL hold 1 and the sclk synchroniser and old-sclk flop SHALL hold CPOL.
REQ-033 Reset mid-frame SHALL abort the frame with no commit; after release, a frame SHALL only start on a fresh synced cs falling edge.

Verification
REQ-034 WIDTH=180, mode 0: shift 180 bits 0xA5 pattern, deselect -> spi_bits equals the pattern; load_pulse once, SYNC_STAGES+2 cycles after cs_b rises.
REQ-035 Readback: second 180-bit frame shifting zeros -> sdo returns the first pattern MSB-first; spi_bits becomes all-zero.
REQ-036 Short/long frames: 179 bits -> frame_err pulse, spi_bits unchanged; 181 bits -> frame_err pulse, spi_bits unchanged; 0 bits -> neither pulse.
REQ-037 Modes: WIDTH=16, CPOL/CPHA in {0,1} x {0,1}, write 0x1234 then read back -> sdo stream 0x1234 and spi_bits 0x1234 in every mode.
REQ-038 Reset: assert rst_b after 90 bits of a frame, release, complete a full frame -> spi_bits = RESET_VAL until the new frame commits; no pulses during the aborted frame.
REQ-039 Priority: force an sclk sample edge in the same synced cycle as deselect on bit 180 -> edge dropped, frame_err pulse, no commit.

Source files
------------

// File: rtl/spi_shadow_register_if.sv
// SPI pin bundle between an external SPI master and the shadow register.
// The slave modport is the view seen by spi_shadow_register.
interface spi_shadow_register_if;
  logic spi_cs_b;
  logic spi_sclk;
  logic spi_sdi;
  logic spi_sdo;

  modport master (
    output spi_cs_b,
    output spi_sclk,
    output spi_sdi,
    input  spi_sdo
  );

  modport slave (
    input  spi_cs_b,
    input  spi_sclk,
    input  spi_sdi,
    output spi_sdo
  );
endinterface

// File: rtl/spi_shadow_register.sv
// SPI-writable shadow register: pins are oversampled on clk, a frame is
// committed to spi_bits only when exactly WIDTH bits were shifted.
module spi_shadow_register #(
  parameter int               WIDTH       = 180,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               SYNC_STAGES = 2,
  parameter int               CPOL        = 0,
  parameter int               CPHA        = 0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  spi_shadow_register_if.slave spi,
  output logic [WIDTH-1:0]     spi_bits,
  output logic                 load_pulse,
  output logic                 frame_err
);

  localparam int             CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(WIDTH + 1);
  localparam logic           IDLE     = CPOL[0];

  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic                   cs_old_reg;
  logic                   sclk_old_reg;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] spi_bits_reg;
  logic [CW-1:0]    cnt_reg;
  logic             sdo_reg;
  logic             load_pulse_reg;
  logic             frame_err_reg;
  logic             commit_ok_reg;
  logic             commit_err_reg;

  logic             cs_s;
  logic             sclk_s;
  logic             sdi_s;
  logic             cs_fall;
  logic             cs_rise;
  logic             selected;
  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             launch_edge;
  logic [WIDTH-1:0] readback;

  // Metastability chains; reset holds them at the deselected / idle levels
  // so a frame can only begin on a fresh synced cs falling edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cs_sync_reg   <= '1;
      sclk_sync_reg <= {SYNC_STAGES{IDLE}};
      sdi_sync_reg  <= '0;
      cs_old_reg    <= 1'b1;
      sclk_old_reg  <= IDLE;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi.spi_cs_b};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi.spi_sclk};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], spi.spi_sdi};
      cs_old_reg    <= cs_sync_reg[SYNC_STAGES-1];
      sclk_old_reg  <= sclk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign cs_s        = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_reg[SYNC_STAGES-1];
  assign cs_fall     = cs_old_reg & ~cs_s;
  assign cs_rise     = ~cs_old_reg & cs_s;
  // Both old and new synced cs low: a deselect in this cycle masks any edge.
  assign selected    = ~cs_old_reg & ~cs_s;
  assign lead_edge   = (sclk_old_reg == IDLE) && (sclk_s != IDLE);
  assign trail_edge  = (sclk_old_reg != IDLE) && (sclk_s == IDLE);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign launch_edge = (CPHA != 0) ? lead_edge  : trail_edge;
  // A re-select right behind a commit must read back the value being committed.
  assign readback    = commit_ok_reg ? shift_reg : spi_bits_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      spi_bits_reg   <= RESET_VAL;
      shift_reg      <= '0;
      cnt_reg        <= '0;
      sdo_reg        <= 1'b1;
      load_pulse_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      commit_ok_reg  <= 1'b0;
      commit_err_reg <= 1'b0;
    end else begin
      load_pulse_reg <= commit_ok_reg;
      frame_err_reg  <= commit_err_reg;
      commit_ok_reg  <= 1'b0;
      commit_err_reg <= 1'b0;
      if (commit_ok_reg) begin
        spi_bits_reg <= shift_reg;
      end

      if (cs_rise) begin
        commit_ok_reg  <= (cnt_reg == CNT_FULL);
        commit_err_reg <= (cnt_reg != CNT_FULL) && (cnt_reg != '0);
        cnt_reg        <= '0;
        sdo_reg        <= 1'b1;
      end else if (cs_fall) begin
        shift_reg <= readback;
        cnt_reg   <= '0;
        sdo_reg   <= readback[WIDTH-1];
      end else if (selected) begin
        if (sample_edge) begin
          shift_reg <= {shift_reg[WIDTH-2:0], sdi_s};
          if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        if (launch_edge) begin
          sdo_reg <= shift_reg[WIDTH-1];
        end
      end
    end
  end

  assign spi.spi_sdo = sdo_reg;
  assign spi_bits    = spi_bits_reg;
  assign load_pulse  = load_pulse_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_spi_shadow_register.sv
// Directed bench: one 180-bit mode-0 instance plus four 16-bit instances,
// one per CPOL/CPHA combination, driven by a bit-banged SPI master.
module tb_spi_shadow_register;
  localparam int S = 2;
  localparam int H = 6;

  logic        clk;
  logic        rst_b;
  logic        cs_b_v [5];
  logic        sclk_v [5];
  logic        sdi_v;
  logic [4:0]  sdo_w;
  logic [4:0]  load_w;
  logic [4:0]  err_w;
  logic [179:0] bits0;
  logic [15:0] bits16 [1:4];

  int checks   = 0;
  int failures = 0;
  int both_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_shadow_register_if if0 ();
  assign if0.spi_cs_b = cs_b_v[0];
  assign if0.spi_sclk = sclk_v[0];
  assign if0.spi_sdi  = sdi_v;
  assign sdo_w[0]     = if0.spi_sdo;

  spi_shadow_register #(.WIDTH(180), .SYNC_STAGES(S), .CPOL(0), .CPHA(0)) u_dut0 (
    .clk        (clk),
    .rst_b      (rst_b),
    .spi        (if0.slave),
    .spi_bits   (bits0),
    .load_pulse (load_w[0]),
    .frame_err  (err_w[0])
  );

  for (genvar gi = 1; gi < 5; gi++) begin : g_mode
    spi_shadow_register_if ifm ();
    assign ifm.spi_cs_b = cs_b_v[gi];
    assign ifm.spi_sclk = sclk_v[gi];
    assign ifm.spi_sdi  = sdi_v;
    assign sdo_w[gi]    = ifm.spi_sdo;
    spi_shadow_register #(.WIDTH(16), .SYNC_STAGES(S),
                          .CPOL((gi - 1) / 2), .CPHA((gi - 1) % 2)) u_dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .spi        (ifm.slave),
      .spi_bits   (bits16[gi]),
      .load_pulse (load_w[gi]),
      .frame_err  (err_w[gi])
    );
  end

  always @(negedge clk) begin
    for (int d = 0; d < 5; d++) begin
      if (load_w[d] && err_w[d]) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic dut_cpol(input int d);
    return (d == 0) ? 1'b0 : logic'(((d - 1) / 2) != 0);
  endfunction

  function automatic logic dut_cpha(input int d);
    return (d == 0) ? 1'b0 : logic'(((d - 1) % 2) != 0);
  endfunction

  // Watches the pulses after a deselect; la is the posedge index of the first load.
  task automatic window(input int d, output int lc, output int la, output int ec);
    lc = 0; la = 0; ec = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (load_w[d]) begin
        lc++;
        if (la == 0) la = k;
      end
      if (err_w[d]) ec++;
    end
    @(negedge clk);
  endtask

  task automatic spi_frame(input int d, input int nbits, input logic [191:0] din,
                           input bit prio, input bit abort,
                           output logic [191:0] dout, output int lc, output int la,
                           output int ec);
    logic cpol;
    logic cpha;
    cpol = dut_cpol(d);
    cpha = dut_cpha(d);
    dout = '0;
    lc = 0; la = 0; ec = 0;
    @(negedge clk);
    cs_b_v[d] = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sdi_v = din[nbits-1-i];
        repeat (H) @(negedge clk);
        dout = {dout[190:0], sdo_w[d]};
        sclk_v[d] = ~cpol;
        if (prio && i == nbits - 1) begin
          cs_b_v[d] = 1'b1;
        end else begin
          repeat (H) @(negedge clk);
          sclk_v[d] = cpol;
        end
      end else begin
        sclk_v[d] = ~cpol;
        sdi_v = din[nbits-1-i];
        repeat (H) @(negedge clk);
        dout = {dout[190:0], sdo_w[d]};
        sclk_v[d] = cpol;
        repeat (H) @(negedge clk);
      end
    end
    if (!abort) begin
      if (!prio) begin
        repeat (H) @(negedge clk);
        cs_b_v[d] = 1'b1;
      end
      window(d, lc, la, ec);
      sclk_v[d] = cpol;
      repeat (H) @(negedge clk);
    end
    $display("frame dut=%0d bits=%0d prio=%0d abort=%0d load=%0d load_at=%0d err=%0d",
             d, nbits, prio, abort, lc, la, ec);
  endtask

  initial begin
    logic [191:0] pat;
    logic [191:0] mask;
    logic [191:0] q;
    logic [191:0] dout;
    int lc, la, ec;

    mask = (192'd1 << 180) - 192'd1;
    pat  = {24{8'hA5}} & mask;
    q    = {6{32'h0F1E_2D3C}} & mask;
    rst_b = 1'b0;
    sdi_v = 1'b0;
    for (int d = 0; d < 5; d++) begin
      cs_b_v[d] = 1'b1;
      sclk_v[d] = dut_cpol(d);
    end
    repeat (4) @(negedge clk);
    chk("reset_bits", {12'b0, bits0}, 192'd0);
    chk("reset_sdo", {191'b0, sdo_w[0]}, 192'd1);
    chk("reset_load", {187'b0, load_w}, 192'd0);
    chk("reset_err", {187'b0, err_w}, 192'd0);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    spi_frame(0, 180, pat, 0, 0, dout, lc, la, ec);
    chk("a5_bits", {12'b0, bits0}, pat);
    chk("a5_load_cnt", 192'(lc), 192'd1);
    chk("a5_load_latency", 192'(la), 192'(S + 2));
    chk("a5_err_cnt", 192'(ec), 192'd0);

    spi_frame(0, 180, 192'd0, 0, 0, dout, lc, la, ec);
    chk("rb_sdo_stream", dout & mask, pat);
    chk("rb_bits_zero", {12'b0, bits0}, 192'd0);
    chk("rb_load_cnt", 192'(lc), 192'd1);

    spi_frame(0, 180, pat, 0, 0, dout, lc, la, ec);
    chk("restore_bits", {12'b0, bits0}, pat);

    spi_frame(0, 179, q, 0, 0, dout, lc, la, ec);
    chk("short_err", 192'(ec), 192'd1);
    chk("short_load", 192'(lc), 192'd0);
    chk("short_bits", {12'b0, bits0}, pat);

    spi_frame(0, 181, q, 0, 0, dout, lc, la, ec);
    chk("long_err", 192'(ec), 192'd1);
    chk("long_load", 192'(lc), 192'd0);
    chk("long_bits", {12'b0, bits0}, pat);

    spi_frame(0, 0, q, 0, 0, dout, lc, la, ec);
    chk("zero_err", 192'(ec), 192'd0);
    chk("zero_load", 192'(lc), 192'd0);
    chk("zero_bits", {12'b0, bits0}, pat);

    spi_frame(0, 180, q, 1, 0, dout, lc, la, ec);
    chk("prio_err", 192'(ec), 192'd1);
    chk("prio_load", 192'(lc), 192'd0);
    chk("prio_bits", {12'b0, bits0}, pat);

    cs_b_v[0] = 1'b0;
    @(negedge clk);
    cs_b_v[0] = 1'b1;
    window(0, lc, la, ec);
    $display("glitch dut=0 load=%0d err=%0d", lc, ec);
    chk("glitch_pulses", 192'(lc + ec), 192'd0);
    chk("glitch_bits", {12'b0, bits0}, pat);

    spi_frame(0, 90, q, 0, 1, dout, lc, la, ec);
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_bits", {12'b0, bits0}, 192'd0);
    chk("midrst_sdo", {191'b0, sdo_w[0]}, 192'd1);
    cs_b_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    window(0, lc, la, ec);
    $display("reset_release dut=0 load=%0d err=%0d", lc, ec);
    chk("midrst_pulses", 192'(lc + ec), 192'd0);
    chk("midrst_bits_held", {12'b0, bits0}, 192'd0);
    spi_frame(0, 180, q, 0, 0, dout, lc, la, ec);
    chk("postrst_bits", {12'b0, bits0}, q);
    chk("postrst_load", 192'(lc), 192'd1);

    for (int m = 1; m < 5; m++) begin
      spi_frame(m, 16, 192'h1234, 0, 0, dout, lc, la, ec);
      chk($sformatf("mode%0d_bits", m - 1), {176'b0, bits16[m]}, 192'h1234);
      chk($sformatf("mode%0d_load", m - 1), 192'(lc), 192'd1);
      spi_frame(m, 16, 192'h0, 0, 0, dout, lc, la, ec);
      chk($sformatf("mode%0d_sdo", m - 1), {176'b0, dout[15:0]}, 192'h1234);
    end

    chk("load_err_exclusive", 192'(both_cnt), 192'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
